// File: rtl/pixel_fetch_ctrl.sv
// pixel_fetch_ctrl
//   Pulls word addresses from the pixel-map address FIFO, reads each valid
//   address from the asynchronous frame-store SRAM and pushes one 16-bit pixel
//   per address into the display pixel FIFO, preserving order. Addresses with
//   the valid bit clear (rotated out of frame) produce BLANK_PIXEL without
//   touching the SRAM. Pixels are counted per frame; at the last pixel of a
//   frame a one-cycle done pulse is raised and the frame's invalid count is
//   published.
//
// Parameters
//   READ_WAIT     cycles the SRAM is enabled before DQ is sampled (1..15)
//   BLANK_PIXEL   pixel value emitted for invalid addresses
//   FRAME_PIXELS  pixels per frame (<= 2^19)
//
// Ports
//   CLK, RESET_N    clock, asynchronous active-low reset
//   iADDR_EMPTY     address FIFO empty
//   iADDR           address FIFO q: [19]=valid, [18:0]=word address
//                   (normal-mode FIFO: q valid the cycle after rdreq)
//   oADDR_RD        address FIFO rdreq
//   oSRAM_ADDR      SRAM word address (registered)
//   oSRAM_CE_N      SRAM chip enable, active low (registered)
//   oSRAM_OE_N      SRAM output enable, active low (registered)
//   iSRAM_DQ        SRAM read data
//   oPIX_DATA       pixel to display FIFO (registered)
//   oPIX_WR         display FIFO wrreq
//   iPIX_FULL       display FIFO full
//   oFRAME_DONE     pulse coincident with the write of a frame's last pixel
//   oFRAME_INVALID  invalid-pixel count of the last completed frame

module pixel_fetch_ctrl #(
  parameter int unsigned READ_WAIT    = 2,
  parameter logic [15:0] BLANK_PIXEL  = 16'h0000,
  parameter int unsigned FRAME_PIXELS = 384000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        iADDR_EMPTY,
  input  logic [19:0] iADDR,
  output logic        oADDR_RD,
  output logic [18:0] oSRAM_ADDR,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  input  logic [15:0] iSRAM_DQ,
  output logic [15:0] oPIX_DATA,
  output logic        oPIX_WR,
  input  logic        iPIX_FULL,
  output logic        oFRAME_DONE,
  output logic [18:0] oFRAME_INVALID
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READ,
    PUSH
  } state_t;

  localparam logic [3:0]  WAIT_INIT = 4'(READ_WAIT);
  localparam logic [18:0] LAST_PIX  = 19'(FRAME_PIXELS - 1);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [18:0] pix_cnt;
  logic [18:0] inv_cnt;

  // Handshakes are combinational so a pixel write and the next pop can share
  // one cycle; that is what gives the 2-cycle invalid / 2+READ_WAIT valid
  // steady-state throughput.
  assign oPIX_WR     = (state == PUSH) && !iPIX_FULL;
  assign oADDR_RD    = !iADDR_EMPTY && ((state == IDLE) || oPIX_WR);
  assign oFRAME_DONE = oPIX_WR && (pix_cnt == LAST_PIX);

  // NOTE: every register in this block is assigned with <= so all of them
  // update together from the same pre-edge values; a blocking = here would
  // let later statements see half-updated state and break the simulation /
  // synthesis match.
  always_ff @(posedge CLK or negedge RESET_N) begin
    // NOTE: the asynchronous reset also forces CE_N/OE_N high, so a reset that
    // lands in the middle of a read releases the SRAM bus without waiting for
    // a clock edge.
    if (!RESET_N) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      pix_cnt        <= '0;
      inv_cnt        <= '0;
      oSRAM_ADDR     <= '0;
      oSRAM_CE_N     <= 1'b1;
      oSRAM_OE_N     <= 1'b1;
      oPIX_DATA      <= '0;
      oFRAME_INVALID <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (oADDR_RD) state <= LOAD;
        end

        // FIFO q is valid now, one cycle after the pop.
        LOAD: begin
          if (iADDR[19]) begin
            oSRAM_ADDR <= iADDR[18:0];
            oSRAM_CE_N <= 1'b0;
            oSRAM_OE_N <= 1'b0;
            wait_cnt   <= WAIT_INIT;
            state      <= READ;
          end else begin
            oPIX_DATA <= BLANK_PIXEL;
            // Saturate rather than wrap so a pathological frame never
            // reports a small invalid count.
            if (inv_cnt != '1) inv_cnt <= inv_cnt + 19'd1;
            state <= PUSH;
          end
        end

        // The enables went low on entry, so sampling when wait_cnt==1 keeps
        // the SRAM enabled for exactly READ_WAIT cycles.
        READ: begin
          if (wait_cnt == 4'd1) begin
            oPIX_DATA  <= iSRAM_DQ;
            oSRAM_CE_N <= 1'b1;
            oSRAM_OE_N <= 1'b1;
            wait_cnt   <= '0;
            state      <= PUSH;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        // oPIX_DATA is held while the display FIFO is full; the pop for the
        // next address only happens together with the write.
        PUSH: begin
          if (oPIX_WR) state <= iADDR_EMPTY ? IDLE : LOAD;
        end

        default: state <= IDLE;
      endcase

      // Writes only occur in PUSH, so this never collides with the invalid
      // increment in LOAD; the invalid count already includes the last pixel.
      if (oPIX_WR) begin
        if (pix_cnt == LAST_PIX) begin
          pix_cnt        <= '0;
          oFRAME_INVALID <= inv_cnt;
          inv_cnt        <= '0;
        end else begin
          pix_cnt <= pix_cnt + 19'd1;
        end
      end
    end
  end

endmodule
